// File: rtl/register_writeback_if.sv
// rtl/register_writeback_if.sv - writeback/read-port bundle for register_writeback
// Ports (slave = register file side):
//   icode, rA, rB, cnd, valE, valM, wb_en : instruction in writeback
//   srcA, srcB                            : decode-stage read addresses
//   valA, valB                            : read data for srcA/srcB
//   dstE, dstM                            : selected write destinations (4'hF = none)
//   halted, ins_err                       : sticky status flags
interface register_writeback_if;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        wb_en;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic        halted;
  logic        ins_err;

  modport slave (
    input  icode, rA, rB, cnd, valE, valM, wb_en, srcA, srcB,
    output valA, valB, dstE, dstM, halted, ins_err
  );

  modport master (
    output icode, rA, rB, cnd, valE, valM, wb_en, srcA, srcB,
    input  valA, valB, dstE, dstM, halted, ins_err
  );
endinterface

// File: rtl/register_writeback.sv
// rtl/register_writeback.sv - Y86-64 style register file with writeback and halt tracking
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous active-high reset
//   wb    : register_writeback_if.slave (writeback inputs, read ports, dst selects, flags)
module register_writeback (
  input  logic                 clk,
  input  logic                 reset,
  register_writeback_if.slave  wb
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_nxt;
  logic        halt_evt;
  logic        bad_icode;
  logic        ins_err_q;
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic [63:0] regs [0:14];

  // Destination selection; everything collapses to "no register" when the
  // slot is empty or the machine has stopped, which also blocks writes.
  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (wb.icode)
      4'h2:                   dst_e = wb.cnd ? wb.rB : RNONE;
      4'h3, 4'h6:             dst_e = wb.rB;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = RRSP;
      default:                dst_e = RNONE;
    endcase
    if (wb.icode == 4'h5 || wb.icode == 4'hB) begin
      dst_m = wb.rA;
    end
    if (!wb.wb_en || state == HALT) begin
      dst_e = RNONE;
      dst_m = RNONE;
    end
  end

  assign wb.dstE = dst_e;
  assign wb.dstM = dst_m;

  // Halt FSM: icode 0 is a clean halt, 12..15 are illegal and also halt.
  always_comb begin
    state_nxt = state;
    bad_icode = (wb.icode >= 4'hC);
    halt_evt  = wb.wb_en && ((wb.icode == 4'h0) || bad_icode);
    case (state)
      RUN:     if (halt_evt) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      ins_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RUN && halt_evt && bad_icode) begin
        ins_err_q <= 1'b1;
      end
    end
  end

  assign wb.halted  = (state == HALT);
  assign wb.ins_err = ins_err_q;

  // Register array. The M write comes second so it wins when both ports
  // target the same register (popq %rsp).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= 64'h0;
      end
    end else begin
      if (dst_e != RNONE) begin
        regs[dst_e] <= wb.valE;
      end
      if (dst_m != RNONE) begin
        regs[dst_m] <= wb.valM;
      end
    end
  end

  // Reads see pre-edge contents only; no write-through bypass.
  assign wb.valA = (wb.srcA == RNONE) ? 64'h0 : regs[wb.srcA];
  assign wb.valB = (wb.srcB == RNONE) ? 64'h0 : regs[wb.srcB];

endmodule
